pkt_ring_buffer: RTL and testbench

Parametrised successor to the single-packet copy-to-memory block. It stores whole received frames in a circular SRAM, commits a frame only when it ends cleanly, and rolls back the write pointer on error, overflow or bad length. Committed frames are queued as length descriptors and streamed out with a valid/ready handshake and SOP/EOP markers. It sits between the MAC receive framer and the switch forwarding logic.

---
 rtl/pkt_ring_buffer.sv | 253 +++++++++++++++++++++++++
 tb/tb_pkt_ring_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ring_buffer.sv
// Frame store: whole frames go into a circular SRAM, only clean frames are committed,
// and committed frames stream out as SOP..EOP bursts driven by a length-descriptor FIFO.
module pkt_ring_buffer #(
    parameter int pDATA_WIDTH        = 8,
    parameter int pDEPTH_RAM         = 4096,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT + 1),
    parameter int pDESC_DEPTH        = pDEPTH_RAM / pMIN_PACKET_LENGHT,
    parameter int pCNT_WIDTH         = 16
) (
    input  logic                          iclk,
    input  logic                          i_rst,
    input  logic                          iwr_valid,
    input  logic [pDATA_WIDTH-1:0]        iwr_data,
    input  logic                          iwr_sop,
    input  logic                          iwr_eop,
    input  logic                          iwr_err,
    input  logic                          ord_ready,
    output logic                          ord_valid,
    output logic [pDATA_WIDTH-1:0]        ord_data,
    output logic                          ord_sop,
    output logic                          ord_eop,
    output logic [pLEN_WIDTH-1:0]         olen_pac,
    output logic                          odesc_valid,
    output logic [$clog2(pDEPTH_RAM):0]   ofree_words,
    output logic [pCNT_WIDTH-1:0]         odrop_cnt,
    output logic [pCNT_WIDTH-1:0]         ocommit_cnt
);

    localparam int AW  = $clog2(pDEPTH_RAM);
    localparam int PW  = AW + 1;
    localparam int DAW = $clog2(pDESC_DEPTH);
    localparam int LW  = pLEN_WIDTH;
    localparam int CW  = pCNT_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP}    wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM}  rstate_t;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {{(CW-1){1'b0}}, b};
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    logic [pDATA_WIDTH-1:0] mem [pDEPTH_RAM];
    logic [pDATA_WIDTH-1:0] mem_q;
    logic [LW-1:0]          desc_mem [pDESC_DEPTH];

    wstate_t       wstate, wstate_n;
    rstate_t       rstate, rstate_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr, rd_ptr_n, rd_next;
    logic [PW-1:0] used, free;
    logic [LW-1:0] len, len_n, fin_len, rd_rem, rd_rem_n, head_len, next_len;
    logic [PW-1:0] fin_ptr;
    logic [AW-1:0] waddr, raddr;
    logic          we, re, start, fin, commit, pop, xfer, sop_q, sop_n, desc_full;
    logic [1:0]    drop_inc;
    logic [DAW-1:0] dhead, dtail;
    logic [DAW:0]   dcnt;
    logic [CW-1:0]  drop_cnt, commit_cnt;

    // Free space is measured against the committed pointer, so a frame in flight never shows.
    assign used        = wr_commit - rd_ptr;
    assign free        = PW'(pDEPTH_RAM) - used;
    assign ofree_words = free;
    assign desc_full   = (dcnt == (DAW+1)'(pDESC_DEPTH));
    assign odesc_valid = (dcnt != '0);
    assign head_len    = desc_mem[dhead];
    assign next_len    = desc_mem[dhead + DAW'(1)];
    assign olen_pac    = odesc_valid ? head_len : '0;
    assign odrop_cnt   = drop_cnt;
    assign ocommit_cnt = commit_cnt;

    // ---------------- write side ----------------
    always_comb begin
        wstate_n    = wstate;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        len_n       = len;
        we          = 1'b0;
        waddr       = wr_ptr[AW-1:0];
        start       = 1'b0;
        fin         = 1'b0;
        fin_len     = len + LW'(1);
        fin_ptr     = wr_ptr + PW'(1);
        commit      = 1'b0;
        drop_inc    = 2'd0;
        if (iwr_valid) begin
            case (wstate)
                W_IDLE: start = iwr_sop;
                W_WRITE: begin
                    if (iwr_sop) begin
                        drop_inc = 2'd1;
                        start    = 1'b1;
                    end else if (len == LW'(pMAX_PACKET_LENGHT) || free == PW'(len) || iwr_err) begin
                        drop_inc = 2'd1;
                        wr_ptr_n = wr_commit;
                        wstate_n = iwr_eop ? W_IDLE : W_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + PW'(1);
                        len_n    = len + LW'(1);
                        fin      = iwr_eop;
                    end
                end
                W_DROP: if (iwr_eop) wstate_n = W_IDLE;
                default: wstate_n = W_IDLE;
            endcase
            // A new SOP always lands at the committed pointer, abandoning any partial frame.
            if (start) begin
                if (free == '0 || iwr_err) begin
                    drop_inc = drop_inc + 2'd1;
                    wr_ptr_n = wr_commit;
                    wstate_n = iwr_eop ? W_IDLE : W_DROP;
                end else begin
                    we       = 1'b1;
                    waddr    = wr_commit[AW-1:0];
                    wr_ptr_n = wr_commit + PW'(1);
                    len_n    = LW'(1);
                    fin      = iwr_eop;
                    fin_len  = LW'(1);
                    fin_ptr  = wr_commit + PW'(1);
                    wstate_n = W_WRITE;
                end
            end
            if (fin) begin
                wstate_n = W_IDLE;
                if (fin_len >= LW'(pMIN_PACKET_LENGHT) && !desc_full) begin
                    commit      = 1'b1;
                    wr_commit_n = fin_ptr;
                    wr_ptr_n    = fin_ptr;
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    wr_ptr_n = wr_commit;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            wstate     <= W_IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            len        <= '0;
            drop_cnt   <= '0;
            commit_cnt <= '0;
        end else begin
            wstate     <= wstate_n;
            wr_ptr     <= wr_ptr_n;
            wr_commit  <= wr_commit_n;
            len        <= len_n;
            drop_cnt   <= sat_add(drop_cnt, drop_inc);
            commit_cnt <= sat_add(commit_cnt, {1'b0, commit});
        end
    end

    always_ff @(posedge iclk) begin
        if (we) mem[waddr] <= iwr_data;
    end

    // ---------------- descriptor FIFO ----------------
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            dhead <= '0;
            dtail <= '0;
            dcnt  <= '0;
        end else begin
            if (commit) dtail <= dtail + DAW'(1);
            if (pop)    dhead <= dhead + DAW'(1);
            case ({commit, pop})
                2'b10:   dcnt <= dcnt + (DAW+1)'(1);
                2'b01:   dcnt <= dcnt - (DAW+1)'(1);
                default: dcnt <= dcnt;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (commit) desc_mem[dtail] <= fin_len;
    end

    // ---------------- read side ----------------
    assign ord_valid = (rstate != R_IDLE);
    assign ord_sop   = sop_q;
    assign ord_eop   = ord_valid && (rd_rem == LW'(1));
    assign ord_data  = mem_q;
    assign xfer      = ord_valid && ord_ready;
    assign rd_next   = rd_ptr + PW'(1);

    // The SRAM output register is the output stage; reads are issued only when it may change.
    always_comb begin
        rstate_n = rstate;
        rd_ptr_n = rd_ptr;
        rd_rem_n = rd_rem;
        sop_n    = sop_q;
        re       = 1'b0;
        raddr    = rd_ptr[AW-1:0];
        pop      = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (odesc_valid) begin
                    re       = 1'b1;
                    rd_rem_n = head_len;
                    sop_n    = 1'b1;
                    rstate_n = R_PRIME;
                end
            end
            R_PRIME, R_STREAM: begin
                rstate_n = R_STREAM;
                if (xfer) begin
                    rd_ptr_n = rd_next;
                    raddr    = rd_next[AW-1:0];
                    sop_n    = 1'b0;
                    if (rd_rem == LW'(1)) begin
                        pop = 1'b1;
                        // Frames are contiguous, so the next frame starts at rd_next.
                        if (dcnt > (DAW+1)'(1)) begin
                            re       = 1'b1;
                            rd_rem_n = next_len;
                            sop_n    = 1'b1;
                            rstate_n = R_PRIME;
                        end else begin
                            rstate_n = R_IDLE;
                        end
                    end else begin
                        re       = 1'b1;
                        rd_rem_n = rd_rem - LW'(1);
                    end
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            rstate <= R_IDLE;
            rd_ptr <= '0;
            rd_rem <= '0;
            sop_q  <= 1'b0;
            mem_q  <= '0;
        end else begin
            rstate <= rstate_n;
            rd_ptr <= rd_ptr_n;
            rd_rem <= rd_rem_n;
            sop_q  <= sop_n;
            if (re) mem_q <= mem[raddr];
        end
    end

endmodule

// File: tb/tb_pkt_ring_buffer.sv
// Directed bench for pkt_ring_buffer: frames are written, expected output words are queued
// on a scoreboard, and a negedge monitor pops and compares every handshaked word.
module tb_pkt_ring_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;

    logic          iclk = 1'b0;
    logic          i_rst = 1'b1;
    logic          iwr_valid = 1'b0;
    logic [DW-1:0] iwr_data = '0;
    logic          iwr_sop = 1'b0, iwr_eop = 1'b0, iwr_err = 1'b0;
    logic          ord_ready = 1'b0;
    logic          ord_valid, ord_sop, ord_eop, odesc_valid;
    logic [DW-1:0] ord_data;
    logic [10:0]   olen_pac;
    logic [12:0]   ofree_words;
    logic [15:0]   odrop_cnt, ocommit_cnt;

    pkt_ring_buffer dut (
        .iclk(iclk), .i_rst(i_rst),
        .iwr_valid(iwr_valid), .iwr_data(iwr_data), .iwr_sop(iwr_sop),
        .iwr_eop(iwr_eop), .iwr_err(iwr_err),
        .ord_ready(ord_ready), .ord_valid(ord_valid), .ord_data(ord_data),
        .ord_sop(ord_sop), .ord_eop(ord_eop),
        .olen_pac(olen_pac), .odesc_valid(odesc_valid), .ofree_words(ofree_words),
        .odrop_cnt(odrop_cnt), .ocommit_cnt(ocommit_cnt)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } word_t;

    word_t sb[$];
    int    total = 0, bad = 0;
    int    sop_seen = 0, eop_seen = 0, min_free = DEPTH;
    bit    rand_ready = 1'b0, ready_fix = 1'b0, bubble_chk = 1'b0;
    bit    prev_stall = 1'b0, prev_eop_xfer = 1'b0;
    logic [9:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer ready changes just after the active edge.
    always @(posedge iclk) begin
        #1;
        ord_ready = rand_ready ? ($urandom_range(1) == 1) : ready_fix;
    end

    always @(negedge iclk) begin
        if (i_rst) begin
            prev_stall    = 1'b0;
            prev_eop_xfer = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({ord_valid, ord_sop, ord_eop, ord_data}), 32'({1'b1, held}));
            if (bubble_chk && prev_eop_xfer && sb.size() != 0)
                chk("no_bubble", 32'({ord_valid, ord_sop}), 32'd3);
            if (ord_valid && ord_ready) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_word observed=%0h expected=none", ord_data);
                end
                if (sb.size() != 0) begin
                    word_t w;
                    w = sb.pop_front();
                    chk("out_word", 32'({ord_sop, ord_eop, ord_data}), 32'({w.sop, w.eop, w.data}));
                end
                if (ord_sop) sop_seen++;
                if (ord_eop) eop_seen++;
            end
            prev_stall    = ord_valid && !ord_ready;
            held          = {ord_sop, ord_eop, ord_data};
            prev_eop_xfer = ord_valid && ord_ready && ord_eop;
            if (int'(ofree_words) < min_free) min_free = int'(ofree_words);
        end
    end

    task automatic send_frame(input int n, input int base, input bit err, input bit good);
        word_t w;
        for (int i = 0; i < n; i++) begin
            @(negedge iclk);
            iwr_valid = 1'b1;
            iwr_data  = DW'(base + i);
            iwr_sop   = (i == 0);
            iwr_eop   = (i == n - 1);
            iwr_err   = err && (i == n - 1);
            if (good) begin
                w.sop  = (i == 0);
                w.eop  = (i == n - 1);
                w.data = DW'(base + i);
                sb.push_back(w);
            end
        end
        @(negedge iclk);
        iwr_valid = 1'b0; iwr_sop = 1'b0; iwr_eop = 1'b0; iwr_err = 1'b0;
    endtask

    task automatic drain(input string tag, input int limit);
        for (int c = 0; c < limit; c++) begin
            if (sb.size() == 0 && !ord_valid) break;
            @(negedge iclk);
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_outs"}, 32'({ord_valid, ord_sop, ord_eop, ord_data, odesc_valid, olen_pac}), 32'd0);
        chk({tag, "_free"}, 32'(ofree_words), 32'(DEPTH));
        chk({tag, "_cnts"}, {odrop_cnt, ocommit_cnt}, 32'd0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge iclk);
        i_rst = 1'b1;
        iwr_valid = 1'b0; iwr_sop = 1'b0; iwr_eop = 1'b0; iwr_err = 1'b0;
        sb.delete();
        @(negedge iclk);
        chk_reset(tag);
        @(negedge iclk);
        i_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int s0, e0;
        repeat (3) @(negedge iclk);
        chk_reset("rst0");
        i_rst = 1'b0;

        // 1: single clean 64-word frame, ready high
        ready_fix = 1'b1;
        send_frame(64, 0, 1'b0, 1'b1);
        chk("t1_desc", 32'({odesc_valid, olen_pac}), 32'({1'b1, 11'd64}));
        chk("t1_free_committed", 32'(ofree_words), 32'd4032);
        drain("t1_drain", 500);
        chk("t1_commit", 32'(ocommit_cnt), 32'd1);
        chk("t1_free_after", 32'(ofree_words), 32'(DEPTH));

        // 2: errored frame then clean frame
        min_free = DEPTH;
        send_frame(100, 8'h10, 1'b1, 1'b0);
        send_frame(64, 8'h80, 1'b0, 1'b1);
        drain("t2_drain", 500);
        chk("t2_drop", 32'(odrop_cnt), 32'd1);
        chk("t2_min_free", 32'(min_free), 32'd4032);
        chk("t2_commit", 32'(ocommit_cnt), 32'd2);

        // 3: fill with 1000-word frames while stalled, overflow the fifth, then drain across the wrap
        ready_fix = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(1000, f * 37, 1'b0, 1'b1);
        chk("t3_free_full", 32'(ofree_words), 32'd96);
        chk("t3_commit", 32'(ocommit_cnt), 32'd6);
        chk("t3_desc", 32'({odesc_valid, olen_pac}), 32'({1'b1, 11'd1000}));
        send_frame(1000, 200, 1'b0, 1'b0);
        chk("t3_overflow_drop", 32'(odrop_cnt), 32'd2);
        chk("t3_free_kept", 32'(ofree_words), 32'd96);
        ready_fix = 1'b1;
        drain("t3_drain", 6000);
        chk("t3_free_after", 32'(ofree_words), 32'(DEPTH));

        // 4: too short and too long frames
        reset_pulse("t4_rst");
        send_frame(32, 0, 1'b0, 1'b0);
        send_frame(1537, 0, 1'b0, 1'b0);
        chk("t4_drop", 32'(odrop_cnt), 32'd2);
        chk("t4_nodesc", 32'(odesc_valid), 32'd0);
        chk("t4_free", 32'(ofree_words), 32'(DEPTH));
        chk("t4_commit", 32'(ocommit_cnt), 32'd0);

        // 5a: two frames with random backpressure
        s0 = sop_seen; e0 = eop_seen;
        rand_ready = 1'b1;
        send_frame(64, 8'h40, 1'b0, 1'b1);
        send_frame(64, 8'h90, 1'b0, 1'b1);
        drain("t5a_drain", 3000);
        chk("t5a_sops", 32'(sop_seen - s0), 32'd2);
        chk("t5a_eops", 32'(eop_seen - e0), 32'd2);
        rand_ready = 1'b0;
        ready_fix  = 1'b0;

        // 5b: two pre-committed frames streamed with ready held high
        send_frame(64, 8'hA0, 1'b0, 1'b1);
        send_frame(64, 8'h05, 1'b0, 1'b1);
        chk("t5b_commit", 32'(ocommit_cnt), 32'd4);
        s0 = sop_seen; e0 = eop_seen;
        bubble_chk = 1'b1;
        ready_fix  = 1'b1;
        drain("t5b_drain", 500);
        bubble_chk = 1'b0;
        chk("t5b_sops", 32'(sop_seen - s0), 32'd2);
        chk("t5b_eops", 32'(eop_seen - e0), 32'd2);

        // 6: reset mid-write, then mid-read, then a clean round trip
        for (int i = 0; i < 30; i++) begin
            @(negedge iclk);
            iwr_valid = 1'b1; iwr_data = DW'(i); iwr_sop = (i == 0); iwr_eop = 1'b0; iwr_err = 1'b0;
        end
        reset_pulse("t6_rst_write");
        send_frame(64, 8'h33, 1'b0, 1'b1);
        repeat (10) @(negedge iclk);
        chk("t6_midread", 32'(ord_valid), 32'd1);
        reset_pulse("t6_rst_read");
        send_frame(64, 8'h55, 1'b0, 1'b1);
        drain("t6_drain", 500);
        chk("t6_commit", 32'(ocommit_cnt), 32'd1);
        chk("t6_free", 32'(ofree_words), 32'(DEPTH));
        chk("t6_drop", 32'(odrop_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
